// File: rtl/mips_fetch_unit_if.sv
// mips_fetch_unit_if: ready-based instruction memory request bus
interface mips_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data;
  modport master(output imem_req, imem_addr, input imem_ready, imem_data);
  modport slave(input imem_req, imem_addr, output imem_ready, imem_data);
endinterface

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: PC owner and fetch stage feeding the control decoder
module mips_fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0040_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      branch_taken,
  input  logic [31:0]               branch_target,
  mips_fetch_unit_if.master         mem,
  output logic [31:0]               instruction,
  output logic                      instr_valid,
  output logic [31:0]               pc_out,
  output logic [31:0]               pc_4,
  output logic [5:0]                op
);
  typedef enum logic {S_BOOT, S_RUN} state_t;
  state_t      state, state_next;
  logic [31:0] pc;
  logic        slot_free, fire;
  always_ff @(posedge clk)
    if (!reset) state <= S_BOOT;
    else state <= state_next;
  always_comb begin
    state_next = S_RUN;
    slot_free = !instr_valid | !stall;
    mem.imem_req = reset & (state == S_RUN) & slot_free & !branch_taken;
  end
  assign fire          = mem.imem_req & mem.imem_ready;
  assign mem.imem_addr = pc;
  assign pc_4          = pc_out + 32'd4;
  assign op            = (reset & instr_valid) ? instruction[31:26] : 6'h3F;
  // redirect outranks both the memory response and the stall hold
  always_ff @(posedge clk)
    if (!reset) begin
      pc          <= PC_RESET;
      instruction <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
    end else if (branch_taken) begin
      pc          <= branch_target & ~32'h3;
      instr_valid <= 1'b0;
    end else if (fire) begin
      instruction <= mem.imem_data;
      pc_out      <= pc;
      pc          <= pc + PC_STEP;
      instr_valid <= 1'b1;
    end else if (instr_valid & !stall) begin
      instr_valid <= 1'b0;
    end
endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb_mips_fetch_unit: directed stimulus with a scoreboard of consumed instructions
module tb_mips_fetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        ready = 1'b1;
  logic [31:0] instruction, pc_out, pc_4;
  logic        instr_valid;
  logic [5:0]  op;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  mips_fetch_unit_if mem();
  mips_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .mem(mem), .instruction(instruction),
    .instr_valid(instr_valid), .pc_out(pc_out), .pc_4(pc_4), .op(op)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0040_0000) ? 32'h2008_0005 : {a[7:2] ^ 6'h08, 10'h000, a[17:2]};
  endfunction
  assign mem.imem_ready = ready;
  assign mem.imem_data  = mem_word(mem.imem_addr);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick(input logic r, input logic s, input logic b, input logic rd, input logic [31:0] t);
    @(posedge clk);
    #1;
    reset = r;
    stall = s;
    branch_taken = b;
    ready = rd;
    branch_target = t;
    @(negedge clk);
  endtask
  always @(negedge clk)
    if (reset && instr_valid && !stall && !branch_taken) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_consume: pc_out %h with empty queue", pc_out);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("sb_pc_out", pc_out, e);
        chk("sb_instruction", instruction, mem_word(e));
      end
    end
  initial begin
    tick(0, 0, 0, 1, 0);
    chk("rst_req", {31'd0, mem.imem_req}, 0);
    chk("rst_op", {26'd0, op}, 32'h3F);
    chk("rst_valid", {31'd0, instr_valid}, 0);
    tick(0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) exp_q.push_back(32'h0040_0000 + 32'(4 * i));
    tick(1, 0, 0, 1, 0);
    chk("boot_bubble_req", {31'd0, mem.imem_req}, 0);
    tick(1, 0, 0, 1, 0);
    chk("first_req", {31'd0, mem.imem_req}, 1);
    chk("first_addr", mem.imem_addr, 32'h0040_0000);
    tick(1, 0, 0, 1, 0);
    chk("first_valid", {31'd0, instr_valid}, 1);
    chk("first_pc_out", pc_out, 32'h0040_0000);
    chk("first_next_addr", mem.imem_addr, 32'h0040_0004);
    chk("first_op", {26'd0, op}, 32'h08);
    chk("first_pc_4", pc_4, 32'h0040_0004);
    tick(1, 0, 0, 1, 0);
    chk("second_op", {26'd0, op}, 32'h09);
    tick(1, 0, 0, 1, 0);
    tick(1, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      tick(1, 1, 0, 1, 0);
      chk("stall_pc_out", pc_out, 32'h0040_0010);
      chk("stall_addr", mem.imem_addr, 32'h0040_0014);
      chk("stall_req", {31'd0, mem.imem_req}, 0);
      chk("stall_instr", instruction, mem_word(32'h0040_0010));
    end
    tick(1, 0, 0, 1, 0);
    chk("resume_addr", mem.imem_addr, 32'h0040_0014);
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0, 0, 0);
      chk("wait_addr", mem.imem_addr, 32'h0040_0018);
      chk("wait_req", {31'd0, mem.imem_req}, 1);
    end
    tick(1, 0, 1, 1, 32'h0040_0103);
    chk("redir_req", {31'd0, mem.imem_req}, 0);
    chk("redir_valid", {31'd0, instr_valid}, 0);
    chk("redir_op", {26'd0, op}, 32'h3F);
    tick(1, 0, 0, 1, 0);
    chk("redir_addr", mem.imem_addr, 32'h0040_0100);
    tick(1, 1, 1, 1, 32'h0040_0200);
    chk("flush_valid_before", {31'd0, instr_valid}, 1);
    exp_q.push_back(32'h0040_0200);
    tick(1, 0, 0, 1, 0);
    chk("flush_valid", {31'd0, instr_valid}, 0);
    chk("flush_addr", mem.imem_addr, 32'h0040_0200);
    tick(1, 0, 0, 1, 0);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    tick(1, 0, 1, 1, 32'hFFFF_FFFC);
    tick(1, 0, 0, 1, 0);
    chk("wrap_addr_hi", mem.imem_addr, 32'hFFFF_FFFC);
    tick(1, 0, 0, 1, 0);
    chk("wrap_pc_4", pc_4, 32'h0000_0000);
    chk("wrap_addr", mem.imem_addr, 32'h0000_0000);
    tick(1, 0, 0, 1, 0);
    chk("wrap_next_addr", mem.imem_addr, 32'h0000_0004);
    tick(0, 0, 0, 1, 0);
    chk("midrst_req", {31'd0, mem.imem_req}, 0);
    exp_q.push_back(32'h0040_0000);
    tick(1, 0, 0, 1, 0);
    chk("midrst_valid", {31'd0, instr_valid}, 0);
    chk("midrst_addr", mem.imem_addr, 32'h0040_0000);
    chk("midrst_bubble", {31'd0, mem.imem_req}, 0);
    chk("midrst_op", {26'd0, op}, 32'h3F);
    tick(1, 0, 0, 1, 0);
    chk("midrst_req_after", {31'd0, mem.imem_req}, 1);
    tick(1, 0, 0, 1, 0);
    tick(1, 1, 0, 1, 0);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
